gestor_niveles: RTL and testbench

GESTOR_NIVELES -- requirements
Module: gestor_niveles

---
 rtl/gestor_niveles.sv | 150 +++++++++++++++
 tb/tb_gestor_niveles.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gestor_niveles.sv
// Food and medicine level manager for the pet: per-second decay, edge-triggered
// refills, and a VIVO/CRITICO/MUERTO health FSM with a grace period.
module gestor_niveles #(
  parameter int TICKS_PER_SEC      = 50_000_000,
  parameter int DECAY_COMIDA_SEC   = 10,
  parameter int DECAY_MEDICINA_SEC = 15,
  parameter int GRACE_SEC          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Activo_Comida,
  input  logic       Activo_Medicina,
  output logic [1:0] Nivel_Comida,
  output logic [1:0] Nivel_Medicina,
  output logic       Alerta_Comida,
  output logic       Alerta_Medicina,
  output logic       Muerte
);

  // state   | meaning
  // VIVO    | both levels nonzero, normal operation
  // CRITICO | a level is 0, grace counter runs on each tick
  // MUERTO  | grace expired; levels frozen, refills ignored until reset

  localparam int PW = (TICKS_PER_SEC > 1)      ? $clog2(TICKS_PER_SEC)      : 1;
  localparam int CW = (DECAY_COMIDA_SEC > 1)   ? $clog2(DECAY_COMIDA_SEC)   : 1;
  localparam int MW = (DECAY_MEDICINA_SEC > 1) ? $clog2(DECAY_MEDICINA_SEC) : 1;
  localparam int GW = (GRACE_SEC > 1)          ? $clog2(GRACE_SEC)          : 1;

  localparam logic [PW-1:0] PRESC_LOAD = PW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] COM_LOAD   = CW'(DECAY_COMIDA_SEC - 1);
  localparam logic [MW-1:0] MED_LOAD   = MW'(DECAY_MEDICINA_SEC - 1);
  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_SEC - 1);

  typedef enum logic [1:0] {
    VIVO    = 2'd0,
    CRITICO = 2'd1,
    MUERTO  = 2'd2
  } estado_t;

  estado_t         estado;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   cnt_com;
  logic [MW-1:0]   cnt_med;
  logic [GW-1:0]   grace;
  logic            prev_com;
  logic            prev_med;
  logic            tick;
  logic            activo;
  logic            refill_com;
  logic            refill_med;

  assign tick       = (presc == '0);
  assign activo     = (estado != MUERTO);
  assign refill_com = Activo_Comida   & ~prev_com & activo;
  assign refill_med = Activo_Medicina & ~prev_med & activo;

  assign Alerta_Comida   = (Nivel_Comida   == 2'd0);
  assign Alerta_Medicina = (Nivel_Medicina == 2'd0);

  always_ff @(posedge clk) begin
    if (reset || tick) presc <= PRESC_LOAD;
    else               presc <= presc - 1'b1;
  end

  // Edge registers reset high so an input held through reset release is not a refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_com <= 1'b1;
      prev_med <= 1'b1;
    end else begin
      prev_com <= Activo_Comida;
      prev_med <= Activo_Medicina;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Nivel_Comida <= 2'd3;
      cnt_com      <= COM_LOAD;
    end else if (activo) begin
      if (refill_com) begin
        if (Nivel_Comida != 2'd3) Nivel_Comida <= Nivel_Comida + 2'd1;
        cnt_com <= COM_LOAD;
      end else if (tick) begin
        if (cnt_com == '0) begin
          if (Nivel_Comida != 2'd0) Nivel_Comida <= Nivel_Comida - 2'd1;
          cnt_com <= COM_LOAD;
        end else begin
          cnt_com <= cnt_com - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Nivel_Medicina <= 2'd3;
      cnt_med        <= MED_LOAD;
    end else if (activo) begin
      if (refill_med) begin
        if (Nivel_Medicina != 2'd3) Nivel_Medicina <= Nivel_Medicina + 2'd1;
        cnt_med <= MED_LOAD;
      end else if (tick) begin
        if (cnt_med == '0) begin
          if (Nivel_Medicina != 2'd0) Nivel_Medicina <= Nivel_Medicina - 2'd1;
          cnt_med <= MED_LOAD;
        end else begin
          cnt_med <= cnt_med - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= VIVO;
      grace  <= '0;
      Muerte <= 1'b0;
    end else begin
      case (estado)
        VIVO: begin
          if (Nivel_Comida == 2'd0 || Nivel_Medicina == 2'd0) begin
            estado <= CRITICO;
            grace  <= '0;
          end
        end
        CRITICO: begin
          if (Nivel_Comida != 2'd0 && Nivel_Medicina != 2'd0) begin
            estado <= VIVO;
            grace  <= '0;
          end else if (tick) begin
            if (grace == GRACE_LAST) begin
              estado <= MUERTO;
              Muerte <= 1'b1;
            end else begin
              grace <= grace + 1'b1;
            end
          end
        end
        MUERTO: Muerte <= 1'b1;
        default: begin
          estado <= VIVO;
          Muerte <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gestor_niveles.sv
// Table-driven bench for gestor_niveles with a small expected-value scoreboard;
// cycle numbers count rising edges after reset release.
module tb_gestor_niveles;

  logic       clk = 1'b0;
  logic       reset;
  logic       ac;
  logic       am;
  logic [1:0] Nivel_Comida;
  logic [1:0] Nivel_Medicina;
  logic       Alerta_Comida;
  logic       Alerta_Medicina;
  logic       Muerte;

  gestor_niveles #(
    .TICKS_PER_SEC(4),
    .DECAY_COMIDA_SEC(2),
    .DECAY_MEDICINA_SEC(3),
    .GRACE_SEC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Activo_Comida(ac),
    .Activo_Medicina(am),
    .Nivel_Comida(Nivel_Comida),
    .Nivel_Medicina(Nivel_Medicina),
    .Alerta_Comida(Alerta_Comida),
    .Alerta_Medicina(Alerta_Medicina),
    .Muerte(Muerte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    bit         rst;
    int         cyc;
    bit         ac;
    bit         am;
    logic [1:0] fc;
    logic [1:0] mc;
    bit         mu;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] fc;
    logic [1:0] mc;
    bit         mu;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input bit r, input int c, input bit a, input bit m,
                     input logic [1:0] f, input logic [1:0] md, input bit mu);
    vec_t v;
    v = '{r, c, a, m, f, md, mu};
    tbl.push_back(v);
  endtask

  task automatic wait_to(input int t);
    int budget;
    budget = 0;
    while (cyc < t && budget < 200) begin
      @(negedge clk);
      budget++;
    end
  endtask

  task automatic check_at(input int t, input logic [1:0] fc, input logic [1:0] mc,
                          input bit mu, input string name);
    exp_t e;
    logic [6:0] got;
    logic [6:0] want;
    e = '{t, fc, mc, mu, name};
    sb.push_back(e);
    wait_to(t);
    e = sb.pop_front();
    n_checks++;
    got  = {Nivel_Comida, Nivel_Medicina, Alerta_Comida, Alerta_Medicina, Muerte};
    want = {e.fc, e.mc, (e.fc == 2'd0), (e.mc == 2'd0), e.mu};
    if (cyc != e.cyc) begin
      $display("FAIL %s: reached cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
    end else if (got !== want) begin
      $display("FAIL %s @cyc %0d: got com=%0d med=%0d alc=%0b alm=%0b muerte=%0b, required com=%0d med=%0d alc=%0b alm=%0b muerte=%0b",
               e.name, cyc, got[6:5], got[4:3], got[2], got[1], got[0],
               want[6:5], want[4:3], want[2], want[1], want[0]);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ac = 1'b0;
    am = 1'b0;
    do_reset();
    check_at(0, 2'd3, 2'd3, 1'b0, "reset_state");

    // Refill, saturation, held-high, medicine refill, collision at food 1
    add(1,  8, 0, 0, 2, 3, 0);
    add(0,  9, 1, 0, 3, 3, 0);
    add(0, 10, 0, 0, 3, 3, 0);
    add(0, 11, 1, 0, 3, 3, 0);
    add(0, 12, 0, 0, 3, 2, 0);
    add(0, 15, 0, 0, 3, 2, 0);
    add(0, 16, 0, 0, 2, 2, 0);
    add(0, 17, 1, 0, 3, 2, 0);
    add(0, 23, 1, 0, 3, 2, 0);
    add(0, 24, 1, 0, 2, 1, 0);
    add(0, 30, 1, 1, 2, 2, 0);
    add(0, 31, 1, 0, 2, 2, 0);
    add(0, 32, 1, 0, 1, 2, 0);
    add(0, 36, 1, 0, 1, 2, 0);
    add(0, 37, 0, 0, 1, 2, 0);
    add(0, 39, 0, 0, 1, 2, 0);
    add(0, 40, 1, 0, 2, 1, 0);
    add(0, 41, 0, 0, 2, 1, 0);
    add(0, 47, 0, 0, 2, 1, 0);
    add(0, 48, 0, 0, 1, 1, 0);
    // Recovery from CRITICO, grace restart, refill on the dying edge
    add(1, 24, 0, 0, 0, 1, 0);
    add(0, 29, 0, 0, 0, 1, 0);
    add(0, 30, 1, 0, 1, 1, 0);
    add(0, 31, 0, 0, 1, 1, 0);
    add(0, 33, 0, 0, 1, 1, 0);
    add(0, 36, 0, 0, 0, 0, 0);
    add(0, 41, 0, 0, 0, 0, 0);
    add(0, 43, 0, 0, 0, 0, 0);
    add(0, 44, 1, 0, 1, 0, 1);
    add(0, 45, 0, 0, 1, 0, 1);
    add(0, 48, 0, 1, 1, 0, 1);
    add(0, 49, 0, 0, 1, 0, 1);
    // Pure decay to death, then refills ignored
    add(1,  1, 0, 0, 3, 3, 0);
    add(0,  7, 0, 0, 3, 3, 0);
    add(0,  8, 0, 0, 2, 3, 0);
    add(0, 11, 0, 0, 2, 3, 0);
    add(0, 12, 0, 0, 2, 2, 0);
    add(0, 16, 0, 0, 1, 2, 0);
    add(0, 23, 0, 0, 1, 2, 0);
    add(0, 24, 0, 0, 0, 1, 0);
    add(0, 31, 0, 0, 0, 1, 0);
    add(0, 32, 0, 0, 0, 1, 1);
    add(0, 40, 0, 0, 0, 1, 1);
    add(0, 41, 1, 0, 0, 1, 1);
    add(0, 42, 0, 0, 0, 1, 1);
    add(0, 43, 0, 1, 0, 1, 1);
    add(0, 44, 0, 0, 0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        ac = 1'b0;
        am = 1'b0;
        do_reset();
        reset = 1'b0;
      end
      wait_to(tbl[i].cyc - 1);
      ac = tbl[i].ac;
      am = tbl[i].am;
      check_at(tbl[i].cyc, tbl[i].fc, tbl[i].mc, tbl[i].mu, $sformatf("vec%0d", i));
    end

    // Reset while dead with feed held high; no refill on release
    ac = 1'b1;
    do_reset();
    check_at(0, 2'd3, 2'd3, 1'b0, "rst_in_muerto");
    reset = 1'b0;
    check_at(8, 2'd2, 2'd3, 1'b0, "decay_after_rst");
    check_at(10, 2'd2, 2'd3, 1'b0, "held_no_refill");
    ac = 1'b0;
    wait_to(11);
    ac = 1'b1;
    check_at(12, 2'd3, 2'd2, 1'b0, "refill_after_rst");
    ac = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
